// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the core (0) and debug port (1).
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the core has fixed priority.
`timescale 1ns/1ps
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    state_t state_n;
    logic   owner;
    logic   we_q;
    logic   win;
    logic   take;

    assign take = (state == IDLE) && (|req);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_owner;

    // Resets to 1 so the core wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_owner <= 1'b1;
        end else if (state == ISSUE) begin
            last_owner <= owner;
        end
    end

    assign win = (req == 2'b11) ? ~last_owner : req[1];
`else
    // Requester 1 only wins when the core is not asking.
    assign win = ~req[0];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (|req) state_n = ISSUE;
            ISSUE:   state_n = we_q ? IDLE : RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        gnt       = 2'b00;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (state == ISSUE) begin
            gnt       = owner ? 2'b10 : 2'b01;
            mem_read  = ~we_q;
            mem_write = we_q;
        end
    end

    // The winner's request is latched in IDLE so memory sees stable values in ISSUE.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner     <= 1'b0;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (take) begin
            owner     <= win;
            we_q      <= we[win];
            mem_addr  <= win ? addr1 : addr0;
            mem_wdata <= win ? wdata1 : wdata0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rvalid <= 2'b00;
            rdata  <= '0;
        end else begin
            rvalid <= 2'b00;
            if (state == RESP) begin
                rvalid <= owner ? 2'b10 : 2'b01;
                rdata  <= mem_rdata;
            end
        end
    end

endmodule
